// File: rtl/tron_pkg.sv
// Shared Tron timing constants and the per-channel tick action type.
package tron_pkg;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DIV_4HZ     = CLK_HZ / 4;
    localparam int unsigned DIV_8HZ     = CLK_HZ / 8;
    localparam int unsigned MIN_DIV_DEF = 1_250_000;
    localparam int unsigned STEP_DEF    = 250_000;

    // What a channel does at the next edge, in priority order.
    typedef enum logic [2:0] {
        ACT_LOAD,
        ACT_REARM,
        ACT_HOLD,
        ACT_TICK,
        ACT_COUNT
    } ch_act_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_tick_gen_if.sv
// Control/status bundle between the game logic and the tick generator.
interface game_tick_gen_if
    import tron_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 28
);
    localparam int unsigned SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0]       enable;
    logic                    pause;
    logic [NUM_CH-1:0]       accel_en;
    logic                    load;
    logic [SEL_W-1:0]        ch_sel;
    logic [CNT_W-1:0]        div_in;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH*CNT_W-1:0] period;

    modport master (
        output enable, pause, accel_en, load, ch_sel, div_in,
        input  tick, period
    );

    modport slave (
        input  enable, pause, accel_en, load, ch_sel, div_in,
        output tick, period
    );

endinterface

// File: rtl/tick_channel.sv
// One programmable tick channel: period register, down-counter and
// load / disable / pause / terminal-count priority.
module tick_channel
    import tron_pkg::*;
#(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned DEFAULT_DIV = DIV_4HZ,
    parameter int unsigned MIN_DIV     = MIN_DIV_DEF,
    parameter int unsigned STEP        = STEP_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             enable,
    input  logic             pause,
    input  logic             accel_en,
    output logic             tick,
    output logic [CNT_W-1:0] per
);

    localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] DEF_V  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);
    localparam logic [CNT_W:0]   STEP_V = (CNT_W+1)'(STEP);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             tick_nx;
    logic [CNT_W-1:0] load_v;
    logic [CNT_W-1:0] accel_v;
    logic [CNT_W:0]   diff;
    ch_act_e          act;

    always_comb begin
        load_v = (div_in < MIN_V) ? MIN_V : div_in;

        // Extra bit catches underflow so a short period saturates at MIN_DIV.
        diff    = {1'b0, per} - STEP_V;
        accel_v = (diff[CNT_W] || (diff[CNT_W-1:0] < MIN_V)) ? MIN_V : diff[CNT_W-1:0];

        if (load)
            act = ACT_LOAD;
        else if (!enable)
            act = ACT_REARM;
        else if (pause)
            act = ACT_HOLD;
        else if (cnt == '0)
            act = ACT_TICK;
        else
            act = ACT_COUNT;
    end

    always_comb begin
        per_nx  = per;
        cnt_nx  = cnt;
        tick_nx = 1'b0;
        unique case (act)
            ACT_LOAD: begin
                per_nx = load_v;
                cnt_nx = load_v - ONE_V;
            end
            ACT_REARM: begin
                cnt_nx = per - ONE_V;
            end
            ACT_HOLD: begin
            end
            ACT_TICK: begin
                tick_nx = 1'b1;
                per_nx  = accel_en ? accel_v : per;
                cnt_nx  = per_nx - ONE_V;
            end
            ACT_COUNT: begin
                cnt_nx = cnt - ONE_V;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            per  <= DEF_V;
            cnt  <= DEF_V - ONE_V;
            tick <= 1'b0;
        end else begin
            per  <= per_nx;
            cnt  <= cnt_nx;
            tick <= tick_nx;
        end
    end

endmodule

// File: rtl/game_tick_gen.sv
// Multi-channel programmable tick generator: NUM_CH tick_channel instances
// sharing pause and a single load port addressed by ch_sel.
module game_tick_gen
    import tron_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned DEFAULT_DIV = DIV_4HZ,
    parameter int unsigned MIN_DIV     = MIN_DIV_DEF,
    parameter int unsigned STEP        = STEP_DEF
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    game_tick_gen_if.slave  bus
);

    logic [NUM_CH-1:0]       ld;
    logic [NUM_CH-1:0]       tick_v;
    logic [NUM_CH*CNT_W-1:0] per_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range ch_sel values match no channel and are dropped.
        assign ld[i] = bus.load && (32'(bus.ch_sel) == 32'(i));

        tick_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .MIN_DIV     (MIN_DIV),
            .STEP        (STEP)
        ) u_ch (
            .clk      (CLOCK_50),
            .resetn   (resetn),
            .load     (ld[i]),
            .div_in   (bus.div_in),
            .enable   (bus.enable[i]),
            .pause    (bus.pause),
            .accel_en (bus.accel_en[i]),
            .tick     (tick_v[i]),
            .per      (per_v[i*CNT_W +: CNT_W])
        );
    end

    assign bus.tick   = tick_v;
    assign bus.period = per_v;

endmodule
